flit_injector: RTL

FLIT_INJECTOR -- requirements
Module: flit_injector

---
 rtl/flit_injector_pkg.sv | 19 +
 rtl/flit_injector.sv | 117 +++++++++++
 2 files changed

// File: rtl/flit_injector_pkg.sv
// Shared NoC definitions for the injector and spidergon nodes:
// flit type codes, head/tail flit count and injector FSM encoding.
package flit_injector_pkg;

  localparam logic [1:0] FT_TAIL     = 2'b00;
  localparam logic [1:0] FT_HEAD     = 2'b01;
  localparam logic [1:0] FT_BODY     = 2'b10;
  localparam logic [1:0] FT_HDR_ONLY = 2'b11;

  localparam int HEAD_TAIL = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2,
    TAIL = 2'd3
  } inj_state_e;

endpackage

// File: rtl/flit_injector.sv
// Packet-to-flit injector: turns one descriptor into head/body/tail
// flits on a valid/ready link into a router input VC.
module flit_injector
  import flit_injector_pkg::*;
#(
  parameter int NUM_OF_NODES    = 8,
  parameter int FLIT_DATA_WIDTH = 16,
  parameter int NODE_ID         = 0,
  parameter int MAX_LEN         = 7
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              pkt_valid,
  output logic                              pkt_ready,
  input  logic [$clog2(NUM_OF_NODES)-1:0]   pkt_dest,
  input  logic [2:0]                        pkt_len,
  output logic [FLIT_DATA_WIDTH+1:0]        flit_out,
  output logic                              flit_valid,
  input  logic                              flit_ready,
  output logic                              pkt_done,
  output logic                              err_self,
  output logic [7:0]                        pkt_seq
);

  localparam int DW = $clog2(NUM_OF_NODES);
  localparam int FW = FLIT_DATA_WIDTH;
  localparam logic [DW-1:0] SELF = DW'(NODE_ID);
  localparam logic [2:0]    LMAX = 3'(MAX_LEN);
  localparam logic [3:0]    SRC  = 4'(NODE_ID);

  inj_state_e    state_q;
  logic [2:0]    len_q;
  logic [2:0]    idx_q;
  logic [FW+1:0] flit_q;
  logic          valid_q;
  logic          done_q;
  logic          err_q;
  logic [7:0]    seq_q;

  logic          xfer;
  logic          last;
  logic          to_tail;
  logic [2:0]    len_sat;
  logic [2:0]    idx_d;
  logic [FW-1:0] head_data;
  logic [FW-1:0] hdr_data;
  logic [FW-1:0] pay_data;

  always_comb begin
    xfer      = valid_q & flit_ready;
    last      = (state_q == TAIL) || (len_q == 3'd0);
    len_sat   = (pkt_len > LMAX) ? LMAX : pkt_len;
    idx_d     = idx_q + 3'd1;
    to_tail   = (idx_d == len_q);
    head_data = FW'({SRC, 4'(pkt_dest)});
    hdr_data  = FW'(pkt_dest);
    pay_data  = FW'({seq_q[3:0], 1'b0, idx_d});
  end

  // The flit register holds the presented flit until it transfers,
  // so a stalled link sees a stable flit_out for free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      flit_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      seq_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pkt_valid) begin
            if (pkt_dest == SELF) begin
              err_q <= 1'b1;
            end else begin
              len_q   <= len_sat;
              idx_q   <= '0;
              valid_q <= 1'b1;
              state_q <= HEAD;
              flit_q  <= (len_sat == 3'd0) ?
                         {FT_HDR_ONLY, hdr_data} :
                         {FT_HEAD, head_data};
            end
          end
        end
        default: begin
          if (xfer) begin
            if (last) begin
              valid_q <= 1'b0;
              flit_q  <= '0;
              done_q  <= 1'b1;
              seq_q   <= seq_q + 8'd1;
              state_q <= IDLE;
            end else begin
              idx_q   <= idx_d;
              state_q <= to_tail ? TAIL : BODY;
              flit_q  <= {to_tail ? FT_TAIL : FT_BODY, pay_data};
            end
          end
        end
      endcase
    end
  end

  assign pkt_ready  = (state_q == IDLE) && !reset;
  assign flit_out   = flit_q;
  assign flit_valid = valid_q;
  assign pkt_done   = done_q;
  assign err_self   = err_q;
  assign pkt_seq    = seq_q;

endmodule
